// File: rtl/muldiv_ctrl.sv
// Iterative MIPS multiply/divide sequencer that owns HI/LO; 34 cycles from accepted start to result.
// start and MTHI/MTLO are dropped while busy; define MULDIV_SIGNED_EN for signed MULT/DIV.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             bzero;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qreg;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, shifted, acc_n;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   qreg_n;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;

    assign prod = {acc[WIDTH-1:0], qreg};

`ifdef MULDIV_SIGNED_EN
    logic sgn_op, a_neg, b_neg;
    logic res_neg, dvd_neg;

    assign sgn_op   = ~op[0];
    assign a_neg    = sgn_op & A[WIDTH-1];
    assign b_neg    = sgn_op & B[WIDTH-1];
    assign mag_a    = a_neg ? -A : A;
    assign mag_b    = b_neg ? -B : B;
    assign prod_fix = res_neg ? -prod : prod;
    assign quo_fix  = res_neg ? -qreg : qreg;
    assign rem_fix  = dvd_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
`else
    logic unused_op;

    assign unused_op = op[0];
    assign mag_a     = A;
    assign mag_b     = B;
    assign prod_fix  = prod;
    assign quo_fix   = qreg;
    assign rem_fix   = acc[WIDTH-1:0];
`endif

    // One shift-add (multiply) or restoring shift-subtract (divide) step.
    always_comb begin
        mul_sum = acc + {1'b0, (qreg[0] ? mcand : {WIDTH{1'b0}})};
        shifted = {acc[WIDTH-1:0], qreg[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, mcand};
        acc_n   = {1'b0, mul_sum[WIDTH:1]};
        qreg_n  = {mul_sum[0], qreg[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH+1]) begin
                acc_n  = diff[WIDTH:0];
                qreg_n = {qreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_n  = shifted;
                qreg_n = {qreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    // A zero divisor forces all-ones quotient; the remainder already equals the dividend.
    always_comb begin
        hi_res = prod_fix[2*WIDTH-1:WIDTH];
        lo_res = prod_fix[WIDTH-1:0];
        if (is_div) begin
            hi_res = rem_fix;
            lo_res = bzero ? {WIDTH{1'b1}} : quo_fix;
        end
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            bzero   <= 1'b0;
            mcand   <= '0;
            acc     <= '0;
            qreg    <= '0;
            hi      <= '0;
            lo      <= '0;
            div0    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            res_neg <= 1'b0;
            dvd_neg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div <= op[1];
                        bzero  <= op[1] & (B == '0);
                        mcand  <= mag_b;
                        qreg   <= mag_a;
                        acc    <= '0;
                        div0   <= 1'b0;
                        count  <= CW'(WIDTH - 1);
                        state  <= RUN;
`ifdef MULDIV_SIGNED_EN
                        res_neg <= a_neg ^ b_neg;
                        dvd_neg <= a_neg;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_n;
                    qreg  <= qreg_n;
                    count <= count - CW'(1);
                    if (count == '0) state <= FIX;
                end
                FIX: begin
                    hi    <= hi_res;
                    lo    <= lo_res;
                    div0  <= bzero;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer for the MIPS execute stage. It owns the HI/LO registers and runs MULT, MULTU, DIV and DIVU over 32 shift-add or shift-subtract cycles. While an operation runs it raises `busy`, so the hazard unit can stall MFHI and MFLO. The ALU boolean/arith paths are untouched; this block sits beside the ALU and is fed the same A/B operands.

## Interface
Parameters:
- `WIDTH`, 32, operand/HI/LO width (only 32 is verified)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  request a new operation, sampled in IDLE or DONE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `A`  in  WIDTH  multiplicand / dividend
- `B`  in  WIDTH  multiplier / divisor
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write strobes
- `wdata`  in  WIDTH  MTHI/MTLO data
- `hi`, `lo`  out  WIDTH  architectural HI/LO, registered
- `busy`  out  1  operation in flight (RUN or FIX)
- `done`  out  1  one-cycle pulse, HI/LO just updated
- `div0`  out  1  sticky until next accepted start: last divide had B==0

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + `start`:
  - Latch `op`, |A| and |B| (magnitudes only for signed ops).
  - Record the result sign and the dividend sign.
  - Clear `div0`, load count=31, go to RUN.
- DONE without `start` goes to IDLE.
- RUN, one iteration per cycle:
  - Multiply: 64-bit shift-add on an {acc, multiplier} register pair.
  - Divide: restoring shift-subtract on {rem, quotient}.
  - count decrements; at count==0 go to FIX.
- FIX:
  - Signed ops with a negative result sign take the two's complement of the 64-bit product, or of the quotient.
  - Remainder sign follows the dividend.
  - HI/LO are written at the edge leaving FIX; go to DONE.
- Results:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- B==0 on DIV/DIVU:
  - Full latency still applies.
  - Result is LO=32'hFFFFFFFF, HI=A (original, unsigned view), `div0`=1.
- DIV of 32'h80000000 by 32'hFFFFFFFF gives LO=32'h80000000, HI=0, with no flag.
- `start` while `busy` is ignored (no queueing).
- `hi_we`/`lo_we` while `busy` are dropped. In IDLE/DONE they write on the same edge.
- MTHI/MTLO coincident with an accepted `start`: the write is applied, then overwritten when the operation completes.
- Width rule: internal accumulators are 2*WIDTH+1 bits. There is no truncation before FIX.

## Timing
- Reset (async, any state, including mid-RUN):
  - State goes to IDLE, count=0.
  - `hi`=`lo`=0; `busy`=`done`=`div0`=0.
  - The in-flight operation is discarded.
- With `start` high in cycle 0 (accepted at edge 1):
  - `busy`=1 in cycles 1–33 (32 RUN + 1 FIX).
  - `hi`/`lo` hold the new result from cycle 34.
  - `done`=1 in cycle 34 only.
- Back-to-back: `start` held in cycle 34 (DONE) launches the next operation with no idle bubble, so `busy` rises again in cycle 35.
- All outputs are registered; `busy` and `done` are decoded from the state register only.
- Old HI/LO stay readable and stable during RUN/FIX.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT/DIV use magnitude-and-sign handling and the FIX negation as described.
- Not defined:
  - Ops 00/10 execute exactly as 01/11 (unsigned).
  - The FIX state is still entered for one cycle, so latency is unchanged at 34 cycles.
  - Sign-recording logic is removed.

## Test plan
- MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF -> cycle 34: hi=32'hFFFFFFFE, lo=32'h00000001, done pulse one cycle, busy cycles 1–33.
- MULT A=-3, B=7 (with `MULDIV_SIGNED_EN`) -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV A=-7, B=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Without the macro the same operands give lo=32'h7FFFFFFC, hi=32'h00000001.
- DIVU A=100, B=0 -> lo=32'hFFFFFFFF, hi=32'h00000064, div0=1. The next accepted start clears div0.
- Reset pulse in cycle 10 of a MULTU -> immediately hi=lo=0, busy=0, and no done pulse appears in cycle 34.
- `start` and `hi_we` (wdata=32'h12345678) in cycle 5 while busy -> both ignored; the original result lands unchanged. In cycle 34 `lo_we`=1 with wdata=5 -> lo=5 from cycle 35.
